// File: rtl/axil_read_master_if.sv
// ---------------------------------------------------------------------------
// axil_read_master_if
// Bundles the two sides of the AXI-Lite read initiator:
//   - core side : single-word read requests (req_*) and buffered responses (resp_*)
//   - bus side  : AXI4-Lite AR and R channels (m_*)
// Modports:
//   master : view of the initiator (drives req_ready, resp_*, m_araddr,
//            m_arvalid, m_rready)
//   slave  : view of the environment (core + responder) driving the rest
// ---------------------------------------------------------------------------
interface axil_read_master_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        resp_ready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  modport master (
    input  req_valid, req_addr, resp_ready,
    input  m_arready, m_rdata, m_rresp, m_rvalid,
    output req_ready, resp_valid, resp_data, resp_err,
    output m_araddr, m_arvalid, m_rready
  );

  modport slave (
    output req_valid, req_addr, resp_ready,
    output m_arready, m_rdata, m_rresp, m_rvalid,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  m_araddr, m_arvalid, m_rready
  );
endinterface

// File: rtl/axil_read_master.sv
// ---------------------------------------------------------------------------
// axil_read_master
// AXI4-Lite read-channel initiator. Accepts one word-aligned read request at a
// time, issues AR, waits for R and holds the returned word in a registered
// response buffer until the consumer takes it. Misaligned requests are
// answered with an error without touching the bus. A per-phase watchdog turns
// a hung responder into an error response; a late R beat after a data-phase
// timeout is swallowed in DRAIN so it cannot be mistaken for the next read.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous, active-high
//   bus_io  : axil_read_master_if.master (request, response and AR/R channels)
// Parameter:
//   TIMEOUT : cycles allowed in each of the ADDR and DATA phases (1..255)
// ---------------------------------------------------------------------------
module axil_read_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  axil_read_master_if.master       bus_io
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e      state_q;
  logic [31:0] araddr_q;
  logic        arvalid_q;
  logic        resp_valid_q;
  logic [31:0] resp_data_q;
  logic        resp_err_q;
  logic [7:0]  wd_cnt_q;
  logic        drain_beat_q;
  logic        drain_taken_q;

  logic        rready_s;
  logic        wd_expired_s;
  logic        ar_hs_s;
  logic        drain_beat_s;
  logic        drain_taken_s;

  // R ready: follows arready in ADDR so a same-cycle R beat is not lost;
  // in DRAIN only until the one late beat has been swallowed.
  always_comb begin
    rready_s = 1'b0;
    unique case (state_q)
      ST_ADDR:  rready_s = bus_io.m_arready;
      ST_DATA:  rready_s = 1'b1;
      ST_DRAIN: rready_s = ~drain_beat_q;
      default:  rready_s = 1'b0;
    endcase
  end

  assign wd_expired_s  = (wd_cnt_q == TIMEOUT_C);
  assign ar_hs_s       = arvalid_q & bus_io.m_arready;
  // Sticky-or-now views of the two DRAIN exit events.
  assign drain_beat_s  = drain_beat_q | bus_io.m_rvalid;
  assign drain_taken_s = drain_taken_q | bus_io.resp_ready;

  assign bus_io.req_ready  = (state_q == ST_IDLE);
  assign bus_io.m_rready   = rready_s;
  assign bus_io.m_araddr   = araddr_q;
  assign bus_io.m_arvalid  = arvalid_q;
  assign bus_io.resp_valid = resp_valid_q;
  assign bus_io.resp_data  = resp_data_q;
  assign bus_io.resp_err   = resp_err_q;

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      araddr_q      <= 32'h0;
      arvalid_q     <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= 32'h0;
      resp_err_q    <= 1'b0;
      wd_cnt_q      <= 8'd0;
      drain_beat_q  <= 1'b0;
      drain_taken_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus_io.req_valid) begin
            if (bus_io.req_addr[1:0] == 2'b00) begin
              araddr_q  <= bus_io.req_addr;
              arvalid_q <= 1'b1;
              wd_cnt_q  <= 8'd0;
              state_q   <= ST_ADDR;
            end else begin
              resp_data_q  <= 32'h0;
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end
          end
        end
        ST_ADDR: begin
          if (ar_hs_s) begin
            arvalid_q <= 1'b0;
            // m_rready mirrors arready here, so rvalid alone completes R.
            if (bus_io.m_rvalid) begin
              resp_data_q  <= bus_io.m_rdata;
              resp_err_q   <= (bus_io.m_rresp != 2'b00);
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end else begin
              wd_cnt_q <= 8'd0;
              state_q  <= ST_DATA;
            end
          end else if (wd_expired_s) begin
            arvalid_q    <= 1'b0;
            resp_data_q  <= 32'h0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end
        ST_DATA: begin
          if (bus_io.m_rvalid) begin
            resp_data_q  <= bus_io.m_rdata;
            resp_err_q   <= (bus_io.m_rresp != 2'b00);
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else if (wd_expired_s) begin
            // The responder still owes a beat; present the error now and
            // swallow that beat in DRAIN.
            resp_data_q   <= 32'h0;
            resp_err_q    <= 1'b1;
            resp_valid_q  <= 1'b1;
            drain_beat_q  <= 1'b0;
            drain_taken_q <= 1'b0;
            state_q       <= ST_DRAIN;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end
        ST_RESP: begin
          if (bus_io.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (drain_beat_s && drain_taken_s) begin
            resp_valid_q  <= 1'b0;
            drain_beat_q  <= 1'b0;
            drain_taken_q <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            drain_beat_q  <= drain_beat_s;
            drain_taken_q <= drain_taken_s;
            // Once taken, the error response is not presented again.
            resp_valid_q  <= ~drain_taken_s;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_read_master.sv
// ---------------------------------------------------------------------------
// tb_axil_read_master
// Scoreboard bench for axil_read_master with a small AXI-Lite responder model
// (zero-wait memory, split AR/R with programmable delay, or AR stall).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axil_read_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axil_read_master_if bus ();

  axil_read_master #(.TIMEOUT(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  // Responder configuration: 0 = memory (AR and R together), 1 = split, 2 = stall
  int          mode;
  int          rdelay;
  logic [31:0] split_data;
  logic [1:0]  split_resp;
  logic [31:0] mem [0:15];
  logic        pend;
  int          pend_cnt;

  // Responder model.
  always @(posedge clk) begin
    if (reset) begin
      bus.m_arready <= 1'b0;
      bus.m_rvalid  <= 1'b0;
      bus.m_rdata   <= 32'h0;
      bus.m_rresp   <= 2'b00;
      pend          <= 1'b0;
      pend_cnt      <= 0;
    end else begin
      if (bus.m_rvalid && bus.m_rready) bus.m_rvalid <= 1'b0;
      if (bus.m_arvalid && bus.m_arready) begin
        bus.m_arready <= 1'b0;
        if (mode == 1) begin
          pend     <= 1'b1;
          pend_cnt <= rdelay - 1;
        end
      end else if (bus.m_arvalid && mode != 2) begin
        bus.m_arready <= 1'b1;
        if (mode == 0) begin
          bus.m_rvalid <= 1'b1;
          bus.m_rdata  <= mem[bus.m_araddr[5:2]];
          bus.m_rresp  <= 2'b00;
        end
      end
      if (pend) begin
        if (pend_cnt == 0) begin
          pend         <= 1'b0;
          bus.m_rvalid <= 1'b1;
          bus.m_rdata  <= split_data;
          bus.m_rresp  <= split_resp;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
    end
  end

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [32:0]  exp_q [$];
  int           cyc = 0;
  int           acc_cyc = 0;
  int           exp_lat = 0;
  logic         prev_rv = 1'b0;
  logic         prev_arv = 1'b0;
  int           arv_rises = 0;
  int           arv_hi = 0;
  int           n_resp = 0;
  int           last_take_cyc = 0;
  logic [31:0]  exp_araddr = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Observe the current (falling-edge) state, then advance one cycle.
  task automatic step();
    logic [32:0] e;
    if (bus.m_arvalid) begin
      arv_hi++;
      if (!prev_arv) begin
        arv_rises++;
        check_eq("araddr", bus.m_araddr, exp_araddr);
      end
    end
    if (bus.resp_valid && !prev_rv && exp_lat > 0)
      check_eq("resp_latency", 32'(cyc - acc_cyc), 32'(exp_lat));
    if (bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_resp", 32'(bus.resp_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check_eq("resp_data", bus.resp_data, e[31:0]);
        check_eq("resp_err", 32'(bus.resp_err), 32'(e[32]));
        n_resp++;
        last_take_cyc = cyc;
      end
    end
    prev_rv  = bus.resp_valid;
    prev_arv = bus.m_arvalid;
    @(negedge clk);
    cyc++;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] ed, input logic ee,
                       input logic keep);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    for (int i = 0; i < 100; i++) begin
      if (bus.req_ready) begin
        exp_q.push_back({ee, ed});
        exp_araddr = addr;
        acc_cyc    = cyc;
        step();
        if (!keep) bus.req_valid = 1'b0;
        return;
      end
      step();
    end
    check_eq("accept_timeout", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) return;
      step();
    end
    check_eq("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_arvalid"},   32'(bus.m_arvalid),  32'h0);
    check_eq({tag, "_rready"},    32'(bus.m_rready),   32'h0);
    check_eq({tag, "_resp_valid"},32'(bus.resp_valid), 32'h0);
    check_eq({tag, "_resp_err"},  32'(bus.resp_err),   32'h0);
    check_eq({tag, "_araddr"},    bus.m_araddr,        32'h0);
    check_eq({tag, "_resp_data"}, bus.resp_data,       32'h0);
    check_eq({tag, "_req_ready"}, 32'(bus.req_ready),  32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int rises0, hi0, n0, first_acc, k;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.resp_ready = 1'b0;
    mode       = 0;
    rdelay     = 1;
    split_data = 32'h0;
    split_resp = 2'b00;
    for (int i = 0; i < 16; i++) mem[i] = 32'hA5000000 + 32'(i * 32'h0101);
    mem[4] = 32'hCAFEF00D;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Aligned read from memory, 3-cycle latency
    bus.resp_ready = 1'b1;
    exp_lat = 3;
    issue(32'h10, 32'hCAFEF00D, 1'b0, 1'b0);
    wait_drain(20);
    issue(32'h24, mem[9], 1'b0, 1'b0);
    wait_drain(20);

    // Misaligned: error after one cycle, no AR
    rises0  = arv_rises;
    exp_lat = 1;
    issue(32'h13, 32'h0, 1'b1, 1'b0);
    wait_drain(20);
    check_eq("misaligned_no_ar", 32'(arv_rises - rises0), 32'h0);

    // Split AR/R with slave error under consumer backpressure
    mode = 1; rdelay = 5; split_data = 32'h1234; split_resp = 2'b10;
    bus.resp_ready = 1'b0;
    exp_lat = 0;
    issue(32'h20, 32'h1234, 1'b1, 1'b0);
    for (int i = 0; i < 40 && !bus.resp_valid; i++) step();
    check_eq("bp_resp_valid", 32'(bus.resp_valid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_hold_valid", 32'(bus.resp_valid), 32'h1);
      check_eq("bp_hold_data", bus.resp_data, 32'h1234);
      check_eq("bp_hold_err", 32'(bus.resp_err), 32'h1);
      check_eq("bp_req_ready", 32'(bus.req_ready), 32'h0);
      step();
    end
    bus.resp_ready = 1'b1;
    wait_drain(20);

    // ADDR-phase timeout: arvalid high for TIMEOUT+1 cycles
    mode = 2;
    hi0  = arv_hi;
    issue(32'h30, 32'h0, 1'b1, 1'b0);
    wait_drain(40);
    check_eq("ar_timeout_hi_cycles", 32'(arv_hi - hi0), 32'd9);

    // DATA-phase timeout, late beat drained, next read is clean
    mode = 1; rdelay = 20; split_data = 32'hDEADBEEF; split_resp = 2'b00;
    issue(32'h34, 32'h0, 1'b1, 1'b0);
    wait_drain(40);
    for (int i = 0; i < 40 && !bus.req_ready; i++) step();
    check_eq("drain_exit", 32'(bus.req_ready), 32'h1);
    mode = 0;
    exp_lat = 3;
    issue(32'h10, 32'hCAFEF00D, 1'b0, 1'b0);
    wait_drain(20);

    // Reset while in DATA
    mode = 1; rdelay = 20;
    exp_lat = 0;
    issue(32'h38, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && bus.m_arvalid; i++) step();
    check_eq("in_data_phase", 32'(bus.m_rready), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    cyc++;
    check_idle_outputs("midreset");
    reset = 1'b0;
    exp_q.delete();
    prev_rv  = 1'b0;
    prev_arv = 1'b0;
    mode = 0;

    // Back-to-back throughput: 4 words in 16 cycles
    bus.resp_ready = 1'b1;
    exp_lat = 3;
    n0 = n_resp;
    issue(32'h0, mem[0], 1'b0, 1'b1);
    first_acc = acc_cyc;
    for (k = 1; k < 4; k++) issue(32'(k * 4), mem[k], 1'b0, (k < 3));
    wait_drain(30);
    check_eq("b2b_count", 32'(n_resp - n0), 32'd4);
    check_eq("b2b_span", 32'(last_take_cyc - first_acc + 1), 32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
